// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding and
// register-address width used by the hazard comparators.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard inputs and stage-control outputs between the pipeline
// datapath (master) and the sequencing controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_mem_read;
  logic                  mem_branch_taken;
  logic                  imem_ready;
  // Data memory handshake: an access completes on the cycle where dmem_req and
  // dmem_ready are both high; req held with ready low stalls everything above WB.
  logic                  dmem_req;
  logic                  dmem_ready;

  logic                  pc_enable;
  logic                  pc_redirect;
  logic                  if_id_enable;
  logic                  if_id_flush;
  logic                  id_ex_enable;
  logic                  id_ex_flush;
  logic                  ex_mem_enable;
  logic                  ex_mem_flush;
  logic                  mem_wb_enable;
  logic                  mem_wb_flush;
  logic                  halted;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_mem_read, mem_branch_taken, imem_ready, dmem_req, dmem_ready,
    input  pc_enable, pc_redirect, if_id_enable, if_id_flush, id_ex_enable,
           id_ex_flush, ex_mem_enable, ex_mem_flush, mem_wb_enable, mem_wb_flush,
           halted, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_mem_read, mem_branch_taken, imem_ready, dmem_req, dmem_ready,
    output pc_enable, pc_redirect, if_id_enable, if_id_flush, id_ex_enable,
           id_ex_flush, ex_mem_enable, ex_mem_flush, mem_wb_enable, mem_wb_flush,
           halted, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose rd feeds an ID source.
// Register x0 is hard-wired zero and never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic                  i_uses_rs1,
  input  logic                  i_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_ex_mem_read,
  output logic                  o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_uses_rs1 && (i_rs1_addr == i_rd_addr);
  assign w_rs2_hit  = i_uses_rs2 && (i_rs2_addr == i_rd_addr);
  assign o_load_use = i_ex_mem_read && (i_rd_addr != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing controller for the 5-stage pipeline: per-stage enable/flush,
// PC redirect, data-memory wait FSM with timeout watchdog, and perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus,
  output state_t                o_dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_events;

  logic w_load_use;
  logic w_dmem_stall;
  logic w_branch;
  logic w_pc_en, w_redirect;
  logic w_if_id_en, w_if_id_fl, w_id_ex_en, w_id_ex_fl;
  logic w_ex_mem_en, w_ex_mem_fl, w_mem_wb_en, w_mem_wb_fl;
  logic w_halted;

  hazard_detect u_hazard_detect (
    .i_rs1_addr    (bus.id_rs1_addr),
    .i_rs2_addr    (bus.id_rs2_addr),
    .i_uses_rs1    (bus.id_uses_rs1),
    .i_uses_rs2    (bus.id_uses_rs2),
    .i_rd_addr     (bus.ex_rd_addr),
    .i_ex_mem_read (bus.ex_mem_read),
    .o_load_use    (w_load_use)
  );

  always_comb begin
    w_pc_en      = 1'b1;
    w_redirect   = 1'b0;
    w_if_id_en   = 1'b1;
    w_if_id_fl   = 1'b0;
    w_id_ex_en   = 1'b1;
    w_id_ex_fl   = 1'b0;
    w_ex_mem_en  = 1'b1;
    w_ex_mem_fl  = 1'b0;
    w_mem_wb_en  = 1'b1;
    w_mem_wb_fl  = 1'b0;
    w_halted     = 1'b0;
    w_dmem_stall = 1'b0;
    w_branch     = 1'b0;
    if (rst) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
      w_if_id_fl  = 1'b1;
      w_id_ex_fl  = 1'b1;
      w_ex_mem_fl = 1'b1;
      w_mem_wb_fl = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.dmem_req && !bus.dmem_ready) begin
            w_dmem_stall = 1'b1;
          end else if (bus.mem_branch_taken) begin
            w_branch    = 1'b1;
            w_redirect  = 1'b1;
            w_if_id_fl  = 1'b1;
            w_id_ex_fl  = 1'b1;
            w_ex_mem_fl = 1'b1;
          end else begin
            if (w_load_use) begin
              w_pc_en    = 1'b0;
              w_if_id_en = 1'b0;
              w_id_ex_fl = 1'b1;
            end
            // With a load-use pending the ID instruction is held, not flushed.
            if (!bus.imem_ready) begin
              w_pc_en = 1'b0;
              if (!w_load_use) w_if_id_fl = 1'b1;
            end
          end
        end
        ST_MEM_WAIT: w_dmem_stall = !bus.dmem_ready;
        default:     w_halted     = 1'b1;
      endcase
      if (w_dmem_stall || w_halted) begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_en  = 1'b0;
        w_ex_mem_en = 1'b0;
        w_mem_wb_fl = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_dmem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            r_state <= ST_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
      if (r_state != ST_HALT && !w_pc_en && r_stall_cycles != {CNT_W{1'b1}})
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_branch && r_flush_events != {CNT_W{1'b1}})
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign bus.pc_enable     = w_pc_en;
  assign bus.pc_redirect   = w_redirect;
  assign bus.if_id_enable  = w_if_id_en;
  assign bus.if_id_flush   = w_if_id_fl;
  assign bus.id_ex_enable  = w_id_ex_en;
  assign bus.id_ex_flush   = w_id_ex_fl;
  assign bus.ex_mem_enable = w_ex_mem_en;
  assign bus.ex_mem_flush  = w_ex_mem_fl;
  assign bus.mem_wb_enable = w_mem_wb_en;
  assign bus.mem_wb_flush  = w_mem_wb_fl;
  assign bus.halted        = w_halted;
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.flush_events  = r_flush_events;
  assign o_dbg_state       = r_state;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline. Drives enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC enable and redirect select, from hazard inputs:
- load-use dependency;
- taken branch resolved at the EX/MEM output;
- instruction-memory not ready;
- multi-cycle data-memory access.

It also runs a data-memory wait FSM with a timeout watchdog and saturating performance counters.

Parameters:
TIMEOUT, 64, max dmem wait cycles before fatal halt (>=2)
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1_addr  in  4  rs1 of instruction in ID
id_rs2_addr  in  4  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd_addr  in  4  rd of instruction in EX (ID/EX output)
ex_mem_read  in  1  instruction in EX is a load
mem_branch_taken  in  1  taken branch/jump at EX/MEM output
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
pc_enable  out  1  PC register update
pc_redirect  out  1  PC selects branch target
if_id_enable, if_id_flush  out  1 each
id_ex_enable, id_ex_flush  out  1 each
ex_mem_enable, ex_mem_flush  out  1 each
mem_wb_enable, mem_wb_flush  out  1 each
halted  out  1  sticky fatal dmem timeout
stall_cycles  out  CNT_W  cycles with pc_enable=0
flush_events  out  CNT_W  count of taken-branch redirects

Behaviour:
- Control outputs are combinational from FSM state and current inputs. Counters, wait counter and state are registered.
- FSM states: RUN, MEM_WAIT, HALT. Reset -> RUN, wait_cnt=0, counters=0.
- Reset output values (rst high): all enables 0, all flushes 1, pc_redirect 0, halted 0.

Default in RUN with no hazard:
- all enables 1, all flushes 0, pc_redirect 0.

Priority in RUN, highest first:
1. dmem stall (dmem_req & !dmem_ready):
   - pc/if_id/id_ex/ex_mem enables 0;
   - mem_wb_enable 1, mem_wb_flush 1 (bubble into WB, no double write);
   - next state MEM_WAIT, wait_cnt<=1.
2. Branch (mem_branch_taken):
   - pc_redirect 1, pc_enable 1;
   - if_id_flush, id_ex_flush, ex_mem_flush all 1;
   - flush_events++.
   - Overrides load-use and imem stall in the same cycle.
3. Load-use (ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr))):
   - pc_enable 0, if_id_enable 0, id_ex_flush 1;
   - exactly one bubble.
4. imem stall (!imem_ready):
   - pc_enable 0, if_id_flush 1;
   - downstream stages advance.
   - Load-use and imem stall together: pc_enable 0 and if_id_enable 0 (hold the ID instruction), id_ex_flush 1.

MEM_WAIT:
- Outputs are identical to the dmem stall case; the branch and load-use inputs are ignored.
- dmem_ready=1: release. All enables 1, mem_wb_flush 0 (result captured); next RUN, wait_cnt<=0.
- Otherwise: wait_cnt++. When wait_cnt==TIMEOUT-1 and still not ready, go to HALT.

HALT:
- halted=1; pc/if_id/id_ex/ex_mem enables 0; mem_wb_flush 1.
- Only rst exits HALT.

Counters:
- stall_cycles increments every cycle pc_enable=0 while not in reset or HALT.
- Both counters saturate at all-ones (no wrap).

Register x0:
- ex_rd_addr==0 never creates a load-use hazard.

Reset mid-wait:
- An asynchronous rst in MEM_WAIT or HALT returns to RUN immediately and clears all counters.

Decomposition:
- Package pipeline_ctrl_pkg: state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2), REG_ADDR_W=4.
- Sub-module hazard_detect: the combinational load-use comparator, reusable by the forwarding unit.
- FSM, wait counter and perf counters stay in the top module.

Test Plan:
- Load x5 in EX, ID add reads rs2=x5 -> one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1; next cycle normal; stall_cycles=1.
- mem_branch_taken=1 together with a load-use condition -> pc_redirect=1; if_id/id_ex/ex_mem flushes =1; pc_enable=1; flush_events=1; no load-use stall.
- dmem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles with upstream enables 0 and mem_wb_flush=1; 4th cycle all enables 1; state RUN.
- TIMEOUT=4, dmem_ready never rises -> HALT after 4 stalled cycles; halted=1 sticky; rst clears halted, state RUN, counters 0.
- Load with rd=x0 and ID reads x0 -> no stall.
- imem_ready=0 for 2 cycles -> if_id_flush=1 and pc_enable=0 for both cycles; ID/EX/MEM advance; stall_cycles=2.
- CNT_W=4, stall held for 20 cycles -> stall_cycles saturates at 15.
